// File: rtl/uart_rx_with_buf_if.sv
// uart_rx_with_buf_if: core-side read port and status flags of the UART receiver
interface uart_rx_with_buf_if;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rdata;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  modport master (output rd_en, err_clr, input rdata, rx_valid, frame_err, overrun);
  modport slave (input rd_en, err_clr, output rdata, rx_valid, frame_err, overrun);
endinterface

// File: rtl/uart_rx_with_buf.sv
// uart_rx_with_buf: 8N1 UART deserialiser feeding a show-ahead byte FIFO
module uart_rx_with_buf #(
  parameter int CLK_PER_BIT = 868,
  parameter int BUF_LOG2    = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rxd,
  uart_rx_with_buf_if.slave  bus
);
  localparam int TW    = $clog2(CLK_PER_BIT) + 1;
  localparam int DEPTH = 1 << BUF_LOG2;
  localparam logic [TW-1:0] HALF = TW'(CLK_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLK_PER_BIT - 1);
  localparam logic [BUF_LOG2:0] CNT_FULL = (BUF_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic                rx_meta, rxs, rxs_prev;
  logic [TW-1:0]       tmr, ld_val;
  logic [2:0]          bcnt;
  logic [7:0]          shreg;
  logic                ld, sh, bclr, stop_ok, stop_bad, tmr_zero;
  logic [7:0]          mem [DEPTH];
  logic [BUF_LOG2-1:0] wr_ptr, rd_ptr;
  logic [BUF_LOG2:0]   cnt;
  logic                full, empty, push, pop;

  assign tmr_zero = (tmr == '0);
  assign full     = (cnt == CNT_FULL);
  assign empty    = (cnt == '0);
  assign pop      = bus.rd_en && !empty;
  assign push     = stop_ok && (!full || pop);

  assign bus.rx_valid = !empty;
  assign bus.rdata    = empty ? 8'h00 : mem[rd_ptr];

  // two-flop synchroniser plus the previous sample used for start-edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rxd;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  // receiver state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // next-state and datapath controls; every sample is taken when the timer hits zero
  always_comb begin
    state_n  = state;
    ld       = 1'b0;
    ld_val   = FULL;
    sh       = 1'b0;
    bclr     = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      IDLE: if (rxs_prev && !rxs) begin
        ld      = 1'b1;
        ld_val  = HALF;
        state_n = START;
      end
      START: if (tmr_zero) begin
        ld      = !rxs;
        bclr    = !rxs;
        state_n = rxs ? IDLE : DATA;
      end
      DATA: if (tmr_zero) begin
        ld      = 1'b1;
        sh      = 1'b1;
        state_n = (bcnt == 3'd7) ? STOP : DATA;
      end
      STOP: if (tmr_zero) begin
        stop_ok  = rxs;
        stop_bad = !rxs;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // bit timer, bit counter and LSB-first shift register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmr   <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else begin
      tmr   <= ld ? ld_val : (tmr_zero ? tmr : tmr - TW'(1));
      bcnt  <= bclr ? 3'd0 : (sh ? bcnt + 3'd1 : bcnt);
      shreg <= sh ? {rxs, shreg[7:1]} : shreg;
    end
  end

  // FIFO storage; contents are only observable through rd_ptr while non-empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + BUF_LOG2'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + BUF_LOG2'(1) : rd_ptr;
      cnt    <= (push && !pop) ? cnt + (BUF_LOG2 + 1)'(1) :
                (pop && !push) ? cnt - (BUF_LOG2 + 1)'(1) : cnt;
    end
  end

  // sticky error flags; a new error in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.frame_err <= stop_bad ? 1'b1 : (bus.err_clr ? 1'b0 : bus.frame_err);
      bus.overrun   <= (stop_ok && full && !pop) ? 1'b1 : (bus.err_clr ? 1'b0 : bus.overrun);
    end
  end
endmodule

// File: tb/tb_uart_rx_with_buf.sv
// tb_uart_rx_with_buf: scoreboard bench with a queue model of the receive FIFO
module tb_uart_rx_with_buf;
  localparam int CPB   = 16;
  localparam int DEPTH = 16;
  localparam int LAT   = 2 + CPB / 2 + 9 * CPB + 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic rxd  = 1'b1;

  uart_rx_with_buf_if itf ();

  uart_rx_with_buf #(.CLK_PER_BIT(CPB), .BUF_LOG2(4)) dut (
    .clk (clk),
    .rstn(rstn),
    .rxd (rxd),
    .bus (itf)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         lat;
  logic [7:0] exp_q[$];
  bit         exp_fe = 0;
  bit         exp_ov = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // a pop observed by the DUT must return the oldest byte the model still holds
  always @(negedge clk) begin
    if (rstn && itf.rd_en && itf.rx_valid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_data: got %0h expected no data", itf.rdata);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (itf.rdata !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %0h expected %0h at %0t", itf.rdata, e, $time);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit pop_at_stop);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(CPB);
    end
    rxd = stop;
    if (pop_at_stop) begin
      tick(CPB / 2 + 2);
      itf.rd_en = 1'b1;
      tick(1);
      itf.rd_en = 1'b0;
      tick(CPB / 2 - 3);
    end else begin
      tick(CPB);
    end
    rxd = 1'b1;
    if (stop) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ov = 1;
    end else begin
      exp_fe = 1;
      tick(CPB);
    end
  endtask

  task automatic pop_one();
    itf.rd_en = 1'b1;
    tick(1);
    itf.rd_en = 1'b0;
  endtask

  task automatic clear_errors();
    itf.err_clr = 1'b1;
    tick(1);
    itf.err_clr = 1'b0;
    exp_fe = 0;
    exp_ov = 0;
  endtask

  task automatic chk_flags(input string tag);
    @(negedge clk);
    chk({tag, "_frame_err"}, itf.frame_err, exp_fe);
    chk({tag, "_overrun"}, itf.overrun, exp_ov);
    chk({tag, "_rx_valid"}, itf.rx_valid, exp_q.size() != 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * DEPTH && exp_q.size() > 0; i++) pop_one();
    @(negedge clk);
    chk({tag, "_model_drained"}, exp_q.size(), 0);
    chk({tag, "_rx_valid_empty"}, itf.rx_valid, 1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    itf.rd_en   = 1'b0;
    itf.err_clr = 1'b0;
    tick(3);
    @(negedge clk);
    chk("reset_rx_valid", itf.rx_valid, 1'b0);
    chk("reset_rdata", itf.rdata, 8'h00);
    chk("reset_frame_err", itf.frame_err, 1'b0);
    chk("reset_overrun", itf.overrun, 1'b0);
    tick(1);
    rstn = 1'b1;
    tick(5);

    fork
      send_frame(8'hA5, 1, 0);
      begin
        lat = 0;
        while (!itf.rx_valid && lat < 3 * LAT) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("single_latency_ok", (lat <= LAT) && itf.rx_valid, 1'b1);
    @(negedge clk);
    chk("single_rdata", itf.rdata, 8'hA5);
    pop_one();
    @(negedge clk);
    chk("single_valid_after_pop", itf.rx_valid, 1'b0);

    send_frame(8'h00, 1, 0);
    send_frame(8'hFF, 1, 0);
    send_frame(8'h3C, 1, 0);
    chk_flags("b2b");
    chk("b2b_entries", exp_q.size(), 3);
    drain("b2b");

    rxd = 1'b0;
    tick(5);
    rxd = 1'b1;
    tick(3 * CPB);
    chk_flags("glitch");

    send_frame(8'h55, 0, 0);
    chk_flags("bad_stop");
    clear_errors();
    @(negedge clk);
    chk("err_clr_frame_err", itf.frame_err, 1'b0);

    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1, 0);
    chk_flags("overrun");
    drain("overrun");
    clear_errors();

    for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h80 + i), 1, 0);
    send_frame(8'hC3, 1, 1);
    chk_flags("full_pop");
    chk("full_pop_entries", exp_q.size(), DEPTH);
    drain("full_pop");

    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rxd = i[0];
      tick(CPB);
    end
    rstn = 1'b0;
    rxd = 1'b1;
    exp_q.delete();
    exp_fe = 0;
    exp_ov = 0;
    tick(3);
    @(negedge clk);
    chk("midreset_rx_valid", itf.rx_valid, 1'b0);
    tick(1);
    rstn = 1'b1;
    tick(2 * CPB);
    send_frame(8'h7E, 1, 0);
    chk_flags("after_reset");
    chk("after_reset_rdata", itf.rdata, 8'h7E);
    drain("after_reset");

    for (int k = 0; k < 30; k++) begin
      send_frame(8'($urandom), $urandom_range(0, 5) != 0, 0);
      tick($urandom_range(0, 12));
      chk_flags("rand");
      repeat ($urandom_range(0, 2)) pop_one();
      if ($urandom_range(0, 3) == 0) clear_errors();
    end
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_with_buf.md
Name: uart_rx_with_buf

Overview:
- Serial receive front end; the input-side counterpart of the core's UART transmit path.
- Deserialises 8N1 UART frames from the external rxd pin.
- Queues received bytes in a small FIFO; the core pops them one at a time through a show-ahead read port.
- Instantiated in processor next to uart_tx_with_buf, on the same clk/rstn.

Parameters:
- CLK_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200). Must be >= 4.
- BUF_LOG2, 4: log2 of FIFO depth (default depth 16).

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- rxd  input  1  UART serial input, idle high, asynchronous to clk
- rd_en  input  1  pop head byte; honoured only when rx_valid=1
- err_clr  input  1  clears frame_err and overrun
- rdata  output  8  head-of-FIFO byte; valid while rx_valid=1
- rx_valid  output  1  FIFO non-empty
- frame_err  output  1  sticky: a frame had stop bit = 0
- overrun  output  1  sticky: a good frame arrived while the FIFO was full

Behaviour:
- Reset (rstn=0, asynchronous) clears all state:
  - rx_valid=0, frame_err=0, overrun=0, rdata=0.
  - Pointers and count are 0; FSM is IDLE.
  - Synchroniser flops and the previous-sample flop are 1.
  - Reset asserted mid-frame abandons the frame; no byte is pushed.
- Synchroniser: two flops on rxd; all logic uses the second-stage output rxs.
- Bit timer: down-counter of width clog2(CLK_PER_BIT)+1; a bit counter 0..7.
- FSM states:
  - IDLE: on rxs_prev=1 and rxs=0, load timer with CLK_PER_BIT/2 - 1 and go to START.
  - START: when the timer reaches 0, sample rxs.
    - rxs=1: false start; go to IDLE, nothing recorded.
    - rxs=0: load timer with CLK_PER_BIT-1, clear the bit counter, go to DATA.
  - DATA: when the timer reaches 0, shift rxs into the shift register LSB-first and reload the timer. After the 8th sample go to STOP.
  - STOP: when the timer reaches 0, sample rxs and go to IDLE on the same cycle.
    - rxs=1 and FIFO not full: push the byte.
    - rxs=1 and FIFO full: drop the byte, set overrun.
    - rxs=0: drop the byte, set frame_err.
- Start-of-frame detection is re-armed in IDLE immediately after the mid-stop-bit sample. Back-to-back frames with a single stop bit must be received.
- FIFO, depth 2^BUF_LOG2:
  - Pointers are BUF_LOG2 bits and wrap modulo depth; count is BUF_LOG2+1 bits.
  - Full = (count == depth). Empty = (count == 0).
  - Show-ahead read: rdata = mem[rd_ptr] combinationally; rx_valid = !empty.
  - A push becomes visible (rx_valid high, rdata updated) the cycle after the stop sample.
  - rd_en with empty: ignored, no pointer movement.
  - Pop advances rd_ptr; the next head appears the following cycle.
- Simultaneous events:
  - Push and pop in the same cycle: both occur, count unchanged.
  - Push while full with a pop in the same cycle: the push is accepted, no overrun.
  - err_clr in the same cycle as a new error: the error wins (flag stays 1).
- Latency: rx_valid rises at most 2 + CLK_PER_BIT/2 + 9*CLK_PER_BIT + 2 cycles after the rxd falling edge of the start bit.
- No parity support, no break detection, no baud auto-detect.

Test Plan (use CLK_PER_BIT=16 for sim speed):
- Single frame 0xA5, correct stop bit -> rx_valid rises within 2+8+144+2 cycles; rdata=0xA5. Pulse rd_en -> rx_valid=0 next cycle.
- Three back-to-back frames 0x00, 0xFF, 0x3C, no idle gap -> FIFO holds 3 entries. Pops return 0x00, 0xFF, 0x3C in order; frame_err=0, overrun=0.
- Glitch: rxd low for 5 cycles, then high -> false start; FSM back to IDLE, rx_valid stays 0, no flags set.
- Frame 0x55 with stop bit driven 0 -> no push, frame_err=1. err_clr pulse -> frame_err=0.
- Send 17 frames 0x00..0x10 with no pops (depth 16) -> overrun=1 and 16 entries held. Pops return 0x00..0x0F; 0x10 is lost; rx_valid=0 after the 16th pop.
- Fill to 16, then assert rd_en exactly on the stop-sample cycle of the 17th frame -> push accepted, overrun=0, count stays 16.
- Assert rstn=0 mid-DATA of a frame, release, then send 0x7E -> only 0x7E is received; all flags 0.
